data_ram_arbiter: RTL

- Shares the single-port word-addressed data RAM between two requesters: port A (CPU load/store unit) and port B (program loader / debug DMA).
- One RAM access per cycle: round-robin arbitration, optional bounded burst lock for port B, address range checking, and registered read data with a valid strobe.
- Sits between the requesters and the data RAM; drives the RAM's addr/datain/write/read pins and consumes its combinational dataout.

---
 rtl/data_ram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single-port, word-addressed data RAM between port A (CPU
//   load/store unit) and port B (program loader / debug DMA). One RAM access
//   per cycle, round-robin between the ports. B can ask for a bounded burst
//   lock while A is waiting. Addresses are range- and alignment-checked, and
//   read data comes back registered with a one-cycle valid strobe.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   a_req/a_write/a_addr/a_wdata   port A request; held stable until a_gnt
//   a_gnt                    port A accepted this cycle (combinational)
//   a_rvalid/a_rdata         port A registered read response
//   a_err                    previous accepted A access was illegal
//   b_*                      same as port A, for port B
//   b_lock                   B requests burst priority over a waiting A
//   ram_addr/ram_datain/ram_write/ram_read   to the RAM
//   ram_dataout              combinational read data from the RAM
module data_ram_arbiter #(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned MAX_LOCK  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_write,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_write,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_datain,
  output logic        ram_write,
  output logic        ram_read,
  input  logic [31:0] ram_dataout
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e             last_q, last_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              a_err_q, a_err_d;
  logic              b_err_q, b_err_d;
  logic [31:0]       a_rdata_q, a_rdata_d;
  logic [31:0]       b_rdata_q, b_rdata_d;

  logic              a_legal, b_legal;
  logic              sel_legal, sel_write;

  // Word aligned and inside the 2^ADDR_BITS-word RAM.
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr[31:ADDR_BITS+2] == '0);
  endfunction

  assign a_legal = addr_legal(a_addr);
  assign b_legal = addr_legal(b_addr);

  // Grant selection. With both requesting, B keeps the port while it holds
  // the lock and has burst budget left; otherwise plain round-robin.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && b_req) begin
      if (b_lock && (last_q == PORT_B) && (lock_cnt_q < LOCK_MAX)) begin
        b_gnt = 1'b1;
      end else if (last_q == PORT_B) begin
        a_gnt = 1'b1;
      end else begin
        b_gnt = 1'b1;
      end
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  // RAM drive. An illegal access is still granted, but it must not touch
  // the RAM, so write/read are both suppressed.
  always_comb begin
    ram_addr   = '0;
    ram_datain = '0;
    sel_legal  = 1'b0;
    sel_write  = 1'b0;
    if (a_gnt) begin
      ram_addr   = a_addr;
      ram_datain = a_wdata;
      sel_legal  = a_legal;
      sel_write  = a_write;
    end else if (b_gnt) begin
      ram_addr   = b_addr;
      ram_datain = b_wdata;
      sel_legal  = b_legal;
      sel_write  = b_write;
    end
    ram_write = sel_legal & sel_write;
    ram_read  = sel_legal & ~sel_write;
  end

  // Next-state computation.
  always_comb begin
    last_d = last_q;
    if (a_gnt) begin
      last_d = PORT_A;
    end else if (b_gnt) begin
      last_d = PORT_B;
    end

    // The burst budget only runs down while A is actually waiting.
    lock_cnt_d = lock_cnt_q;
    if (a_gnt || !b_lock) begin
      lock_cnt_d = '0;
    end else if (b_gnt && a_req && (lock_cnt_q != LOCK_MAX)) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end

    a_rvalid_d = a_gnt & ~a_write;
    a_err_d    = a_gnt & ~a_legal;
    a_rdata_d  = a_rdata_q;
    if (a_gnt && !a_write) begin
      a_rdata_d = a_legal ? ram_dataout : '0;
    end

    b_rvalid_d = b_gnt & ~b_write;
    b_err_d    = b_gnt & ~b_legal;
    b_rdata_d  = b_rdata_q;
    if (b_gnt && !b_write) begin
      b_rdata_d = b_legal ? ram_dataout : '0;
    end
  end

  // last resets to B so that A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= PORT_B;
      lock_cnt_q <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign a_err    = a_err_q;
  assign b_rvalid = b_rvalid_q;
  assign b_rdata  = b_rdata_q;
  assign b_err    = b_err_q;

endmodule
